module_debounce_pulse: RTL and testbench

MODULE_DEBOUNCE_PULSE -- requirements
Module: module_debounce_pulse

---
 rtl/debounce_pkg.sv | 15 +
 rtl/module_debounce_channel.sv | 130 +++++++++++++
 rtl/module_debounce_pulse.sv | 57 +++++
 tb/tb_module_debounce_pulse.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debounce block.
package debounce_pkg;

  // Number of flops in each raw-button synchronizer.
  localparam int SYNC_STAGES = 2;

  // Per-channel debounce FSM state.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } db_state_e;

endpackage

// File: rtl/module_debounce_channel.sv
// One debounce channel: synchronizer, debounce FSM with a saturating
// counter, and a registered single-cycle press pulse.
// Optional feature macro: DEBOUNCE_AUTOREPEAT_EN (periodic repeat pulse
// while the button stays held in PRESSED).
//
// Handshake: none. pulse is a registered strobe, high for exactly one
// clk_i cycle per accepted press (or repeat); there is no ready/ack.
module module_debounce_channel
  import debounce_pkg::*;
#(
  parameter int COUNT_MAX = 100000
`ifdef DEBOUNCE_AUTOREPEAT_EN
  , parameter int REPEAT_MAX = 5000000
`endif
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      btn_i,
  output logic      pulse,
  output db_state_e state_dbg
);

  localparam int CNT_W = $clog2(COUNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(COUNT_MAX);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  db_state_e              state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   rpt_fire;

  // Bring the asynchronous button into the clk_i domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign btn_sync  = sync_q[SYNC_STAGES-1];
  assign state_dbg = state;

  // The debounce counter holds at COUNT_MAX instead of wrapping.
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_MAX > 1) ? $clog2(REPEAT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_MAX - 1);

  logic [RPT_W-1:0] rpt_cnt;

  // Repeat interval counter: runs only while held in PRESSED, restarts
  // from zero on every PRESSED entry and after each repeat pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_cnt <= '0;
    end else if ((state != ST_PRESSED) || !btn_sync) begin
      rpt_cnt <= '0;
    end else if (rpt_cnt == RPT_LAST) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  assign rpt_fire = (state == ST_PRESSED) && btn_sync && (rpt_cnt == RPT_LAST);
`else
  assign rpt_fire = 1'b0;
`endif

  // Debounce FSM; the pulse is registered here so outputs never see a
  // combinational path from the button.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_sync) begin
            state <= ST_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!btn_sync) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_PRESSED;
            cnt   <= '0;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!btn_sync) begin
            state <= ST_WAIT_LOW;
            cnt   <= '0;
          end else begin
            pulse <= rpt_fire;
          end
        end
        ST_WAIT_LOW: begin
          // A high sample here is release bounce: back to PRESSED, no pulse.
          if (btn_sync) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/module_debounce_pulse.sv
// Two independent push-button debouncers producing single-cycle press
// pulses (clk_en1/clk_en2) for the colour-control stage. Both pulses may
// be high in the same cycle; arbitration happens downstream.
// Optional feature macro: DEBOUNCE_AUTOREPEAT_EN (held-button auto-repeat
// every REPEAT_MAX cycles).
module module_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int COUNT_MAX  = 100000,
  parameter int REPEAT_MAX = 5000000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      btn1_i,
  input  logic      btn2_i,
  output logic      clk_en1,
  output logic      clk_en2,
  output db_state_e dbg_state1,
  output db_state_e dbg_state2
);

  // Channels are only built for legal parameters; otherwise the outputs
  // are tied inactive.
  if ((COUNT_MAX >= 2) && (REPEAT_MAX >= 1)) begin : g_channels
    module_debounce_channel #(
      .COUNT_MAX(COUNT_MAX)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      , .REPEAT_MAX(REPEAT_MAX)
`endif
    ) u_ch1 (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .btn_i    (btn1_i),
      .pulse    (clk_en1),
      .state_dbg(dbg_state1)
    );

    module_debounce_channel #(
      .COUNT_MAX(COUNT_MAX)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      , .REPEAT_MAX(REPEAT_MAX)
`endif
    ) u_ch2 (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .btn_i    (btn2_i),
      .pulse    (clk_en2),
      .state_dbg(dbg_state2)
    );
  end else begin : g_bad_params
    assign clk_en1    = 1'b0;
    assign clk_en2    = 1'b0;
    assign dbg_state1 = ST_IDLE;
    assign dbg_state2 = ST_IDLE;
  end

endmodule

// File: tb/tb_module_debounce_pulse.sv
// Bench for module_debounce_pulse with COUNT_MAX=4, REPEAT_MAX=8.
// Directed table of scenarios plus randomized traffic against a
// run-length reference model. Honors DEBOUNCE_AUTOREPEAT_EN.
module tb_module_debounce_pulse;
  import debounce_pkg::*;

  localparam int CM = 4;
  localparam int RM = 8;

  // ---------------- clock / reset / DUT ----------------
  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      b1  = 1'b0;
  logic      b2  = 1'b0;
  logic      en1;
  logic      en2;
  db_state_e st1;
  db_state_e st2;

  always #5 clk = ~clk;

  module_debounce_pulse #(
    .COUNT_MAX (CM),
    .REPEAT_MAX(RM)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .btn1_i    (b1),
    .btn2_i    (b2),
    .clk_en1   (en1),
    .clk_en2   (en2),
    .dbg_state1(st1),
    .dbg_state2(st2)
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Each channel is described by run lengths of the synchronized level:
  // a press is accepted after CM+1 consecutive high samples, a release
  // after CM+1 consecutive low samples; a high during a release run
  // restarts the held period. Repeats fire every RM held samples.
  logic m_sa[2];
  logic m_sb[2];
  bit   m_pressed[2];
  int   m_hi[2];
  int   m_lo[2];
  int   m_held[2];
  bit   m_pulse[2];

  task automatic model_step(input logic r, input logic x1, input logic x2);
    logic raw;
    logic s;
    for (int c = 0; c < 2; c++) begin
      raw = (c == 0) ? x1 : x2;
      if (r) begin
        m_sa[c] = 1'b0; m_sb[c] = 1'b0; m_pressed[c] = 0;
        m_hi[c] = 0; m_lo[c] = 0; m_held[c] = 0; m_pulse[c] = 0;
      end else begin
        s = m_sb[c];
        m_sb[c] = m_sa[c];
        m_sa[c] = raw;
        m_pulse[c] = 0;
        if (!m_pressed[c]) begin
          if (s) begin
            m_hi[c]++;
            if (m_hi[c] == CM + 1) begin
              m_pressed[c] = 1; m_pulse[c] = 1;
              m_hi[c] = 0; m_lo[c] = 0; m_held[c] = 0;
            end
          end else begin
            m_hi[c] = 0;
          end
        end else if (s) begin
          if (m_lo[c] > 0) begin
            m_lo[c] = 0; m_held[c] = 0;
          end else begin
            m_held[c]++;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            if (m_held[c] % RM == 0) m_pulse[c] = 1;
`endif
          end
        end else begin
          m_lo[c]++;
          if (m_lo[c] == CM + 1) begin
            m_pressed[c] = 0; m_hi[c] = 0;
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs, advance one edge (model follows), settle 1 time unit.
  task automatic tick(input logic r, input logic x1, input logic x2);
    rst = r; b1 = x1; b2 = x2;
    @(posedge clk);
    model_step(r, x1, x2);
    #1;
  endtask

  task automatic check_out(input string tag);
    logic [1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected value queued", tag);
    end else begin
      e = exp_q.pop_front();
      if ({en2, en1} !== e) begin
        n_fail++;
        $display("FAIL %s: clk_en2,clk_en1=%b%b expected %b%b", tag, en2, en1, e[1], e[0]);
      end
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      exp_q.push_back(2'b00);
      check_out($sformatf("reset_%0d", k));
    end
    n_tests++;
    if ((st1 !== ST_IDLE) || (st2 !== ST_IDLE)) begin
      n_fail++;
      $display("FAIL reset_state: state1=%0d state2=%0d expected 0 0", st1, st2);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    int          n;
    logic [47:0] r;
    logic [47:0] x1;
    logic [47:0] x2;
    logic [47:0] e1;
    logic [47:0] e2;
    bit          chk_idle;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [47:0] rng(input int lo, input int hi);
    logic [47:0] m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [47:0] bitm(input int k);
    logic [47:0] m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [47:0] alt(input int hi);
    logic [47:0] m = '0;
    for (int k = 0; k <= hi; k += 2) m[k] = 1'b1;
    return m;
  endfunction

  task automatic add_vec(input string nm, input int n, input logic [47:0] r,
                         input logic [47:0] x1, input logic [47:0] x2,
                         input logic [47:0] e1, input logic [47:0] e2, input bit ci);
    vec_t v;
    v.name = nm; v.n = n; v.r = r; v.x1 = x1; v.x2 = x2;
    v.e1 = e1; v.e2 = e2; v.chk_idle = ci;
    vecs.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  logic [47:0] hold_exp;
  int          hold_cnt[2];
  logic        lvl[2];
  logic        rr;

  initial begin
    hold_exp = bitm(6);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    hold_exp = bitm(6) | bitm(14) | bitm(22) | bitm(30);
`endif
    add_vec("clean_press",     12, '0,        rng(0, 11), '0, bitm(6), '0, 0);
    add_vec("press_bounce",    16, '0,        rng(0, 1) | rng(3, 15), '0, bitm(9), '0, 0);
    add_vec("simultaneous",    10, '0,        rng(0, 9), rng(0, 9), bitm(6), bitm(6), 0);
    add_vec("reset_mid",       16, rng(3, 4), rng(0, 15), '0, bitm(11), '0, 0);
    add_vec("release_bounce",  24, '0,        rng(0, 9) | bitm(11), '0, bitm(6), '0, 1);
    add_vec("release_repress", 34, '0,        rng(0, 9) | bitm(11) | rng(24, 33), '0,
            bitm(6) | bitm(30), '0, 0);
    add_vec("hold_30",         32, '0,        rng(0, 31), '0, hold_exp, '0, 0);
    add_vec("short_press",     12, '0,        rng(0, 3), '0, '0, '0, 0);
    add_vec("min_press",       12, '0,        rng(0, 4), '0, bitm(6), '0, 0);
    add_vec("independent",     12, '0,        alt(11), rng(0, 11), '0, bitm(6), 0);

    foreach (vecs[vi]) begin
      do_reset();
      for (int i = 0; i < vecs[vi].n; i++) begin
        tick(vecs[vi].r[i], vecs[vi].x1[i], vecs[vi].x2[i]);
        exp_q.push_back({vecs[vi].e2[i], vecs[vi].e1[i]});
        check_out($sformatf("%s_c%0d", vecs[vi].name, i));
      end
      if (vecs[vi].chk_idle) begin
        n_tests++;
        if (st1 !== ST_IDLE) begin
          n_fail++;
          $display("FAIL %s_idle: state1=%0d expected %0d", vecs[vi].name, st1, ST_IDLE);
        end
      end
    end

    // Randomized traffic against the reference model.
    do_reset();
    hold_cnt[0] = 0; hold_cnt[1] = 0;
    lvl[0] = 1'b0;   lvl[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold_cnt[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          hold_cnt[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 40))
                                                    : int'($urandom_range(1, 5));
        end
        hold_cnt[c]--;
      end
      rr = ($urandom_range(0, 299) == 0);
      tick(rr, lvl[0], lvl[1]);
      exp_q.push_back({m_pulse[1], m_pulse[0]});
      check_out($sformatf("random_c%0d", cyc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
